dma_wr_desc_throttle: RTL and testbench

Per-port write-descriptor admission controller placed between DMA clients and the write-path descriptor/RAM-read mux.
- Each port has an enable bit and a cap on outstanding write operations (descriptors issued, status not yet returned).
- Admitted descriptors pass through a one-deep register stage per port.
- Returning status is registered back to the client, and the port's in-flight count is decremented.
- The block provides drain/idle indication so software can quiesce a port safely.

---
 rtl/dma_wr_desc_throttle_pkg.sv | 9 +
 rtl/dma_wr_desc_throttle_if.sv | 52 +++++
 rtl/dma_wr_desc_throttle_port.sv | 75 +++++++
 rtl/dma_wr_desc_throttle.sv | 64 ++++++
 tb/tb_dma_wr_desc_throttle.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/dma_wr_desc_throttle_pkg.sv
// dma_wr_desc_throttle_pkg: shared constants and helpers for the write-descriptor throttle
package dma_wr_desc_throttle_pkg;
  localparam int ERR_WIDTH = 4;
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] HELD = 1'b1;
  function automatic int cnt_width(input int op_limit);
    return $clog2(op_limit + 1);
  endfunction
endpackage

// File: rtl/dma_wr_desc_throttle_if.sv
// dma_wr_desc_throttle_if: flattened descriptor/status buses between clients, throttle and mux
interface dma_wr_desc_throttle_if
  import dma_wr_desc_throttle_pkg::*;
#(
  parameter int PORTS = 2,
  parameter int DMA_ADDR_WIDTH = 64,
  parameter int RAM_SEL_WIDTH = 2,
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int LEN_WIDTH = 16,
  parameter int TAG_WIDTH = 8
);
  logic [PORTS*DMA_ADDR_WIDTH-1:0] s_axis_write_desc_dma_addr;
  logic [PORTS*RAM_SEL_WIDTH-1:0] s_axis_write_desc_ram_sel;
  logic [PORTS*RAM_ADDR_WIDTH-1:0] s_axis_write_desc_ram_addr;
  logic [PORTS*LEN_WIDTH-1:0] s_axis_write_desc_len;
  logic [PORTS*TAG_WIDTH-1:0] s_axis_write_desc_tag;
  logic [PORTS-1:0] s_axis_write_desc_valid;
  logic [PORTS-1:0] s_axis_write_desc_ready;
  logic [PORTS*DMA_ADDR_WIDTH-1:0] m_axis_write_desc_dma_addr;
  logic [PORTS*RAM_SEL_WIDTH-1:0] m_axis_write_desc_ram_sel;
  logic [PORTS*RAM_ADDR_WIDTH-1:0] m_axis_write_desc_ram_addr;
  logic [PORTS*LEN_WIDTH-1:0] m_axis_write_desc_len;
  logic [PORTS*TAG_WIDTH-1:0] m_axis_write_desc_tag;
  logic [PORTS-1:0] m_axis_write_desc_valid;
  logic [PORTS-1:0] m_axis_write_desc_ready;
  logic [PORTS*TAG_WIDTH-1:0] s_axis_write_desc_status_tag;
  logic [PORTS*ERR_WIDTH-1:0] s_axis_write_desc_status_error;
  logic [PORTS-1:0] s_axis_write_desc_status_valid;
  logic [PORTS*TAG_WIDTH-1:0] m_axis_write_desc_status_tag;
  logic [PORTS*ERR_WIDTH-1:0] m_axis_write_desc_status_error;
  logic [PORTS-1:0] m_axis_write_desc_status_valid;
  modport master (
    input s_axis_write_desc_dma_addr, s_axis_write_desc_ram_sel, s_axis_write_desc_ram_addr,
    input s_axis_write_desc_len, s_axis_write_desc_tag, s_axis_write_desc_valid,
    output s_axis_write_desc_ready,
    output m_axis_write_desc_dma_addr, m_axis_write_desc_ram_sel, m_axis_write_desc_ram_addr,
    output m_axis_write_desc_len, m_axis_write_desc_tag, m_axis_write_desc_valid,
    input m_axis_write_desc_ready,
    input s_axis_write_desc_status_tag, s_axis_write_desc_status_error, s_axis_write_desc_status_valid,
    output m_axis_write_desc_status_tag, m_axis_write_desc_status_error, m_axis_write_desc_status_valid
  );
  modport slave (
    output s_axis_write_desc_dma_addr, s_axis_write_desc_ram_sel, s_axis_write_desc_ram_addr,
    output s_axis_write_desc_len, s_axis_write_desc_tag, s_axis_write_desc_valid,
    input s_axis_write_desc_ready,
    input m_axis_write_desc_dma_addr, m_axis_write_desc_ram_sel, m_axis_write_desc_ram_addr,
    input m_axis_write_desc_len, m_axis_write_desc_tag, m_axis_write_desc_valid,
    output m_axis_write_desc_ready,
    output s_axis_write_desc_status_tag, s_axis_write_desc_status_error, s_axis_write_desc_status_valid,
    input m_axis_write_desc_status_tag, m_axis_write_desc_status_error, m_axis_write_desc_status_valid
  );
endinterface

// File: rtl/dma_wr_desc_throttle_port.sv
// dma_wr_desc_throttle_port: one port's hold register, in-flight counter, status stage and stickies
module dma_wr_desc_throttle_port
  import dma_wr_desc_throttle_pkg::*;
#(
  parameter int DMA_ADDR_WIDTH = 64,
  parameter int RAM_SEL_WIDTH = 2,
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int LEN_WIDTH = 16,
  parameter int TAG_WIDTH = 8,
  parameter int OP_LIMIT = 16,
  parameter int CNT_WIDTH = cnt_width(OP_LIMIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear_sticky,
  input  logic [DMA_ADDR_WIDTH-1:0] s_dma_addr,
  input  logic [RAM_SEL_WIDTH-1:0] s_ram_sel,
  input  logic [RAM_ADDR_WIDTH-1:0] s_ram_addr,
  input  logic [LEN_WIDTH-1:0] s_len,
  input  logic [TAG_WIDTH-1:0] s_tag,
  input  logic s_valid,
  output logic s_ready,
  output logic [DMA_ADDR_WIDTH-1:0] m_dma_addr,
  output logic [RAM_SEL_WIDTH-1:0] m_ram_sel,
  output logic [RAM_ADDR_WIDTH-1:0] m_ram_addr,
  output logic [LEN_WIDTH-1:0] m_len,
  output logic [TAG_WIDTH-1:0] m_tag,
  output logic m_valid,
  input  logic m_ready,
  input  logic [TAG_WIDTH-1:0] st_tag,
  input  logic [ERR_WIDTH-1:0] st_error,
  input  logic st_valid,
  output logic [TAG_WIDTH-1:0] m_st_tag,
  output logic [ERR_WIDTH-1:0] m_st_error,
  output logic m_st_valid,
  output logic [CNT_WIDTH-1:0] inflight_count,
  output logic idle,
  output logic status_error_sticky,
  output logic underflow_sticky
);
  logic [0:0] state;
  logic accept;
  logic dec;
  // admission: room under the cap and the hold register free or draining this cycle
  always_comb begin
    s_ready = rst_n & enable & (inflight_count < CNT_WIDTH'(OP_LIMIT)) & ((state == EMPTY) | m_ready);
    accept = s_valid & s_ready;
    dec = st_valid & (inflight_count != '0);
    m_valid = state == HELD;
    idle = (state == EMPTY) & (inflight_count == '0);
  end
  // EMPTY/HELD: a new accept always refills, otherwise hold until the mux takes it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= EMPTY;
    else state <= (accept | (m_valid & !m_ready)) ? HELD : EMPTY;
  // payload registers need no reset; valid flags qualify them
  always_ff @(posedge clk) begin
    if (accept) {m_dma_addr, m_ram_sel, m_ram_addr, m_len, m_tag} <= {s_dma_addr, s_ram_sel, s_ram_addr, s_len, s_tag};
    if (st_valid) {m_st_tag, m_st_error} <= {st_tag, st_error};
  end
  // in-flight count, registered status valid and sticky flags (set beats clear)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      inflight_count <= '0;
      m_st_valid <= 1'b0;
      status_error_sticky <= 1'b0;
      underflow_sticky <= 1'b0;
    end else begin
      inflight_count <= inflight_count + CNT_WIDTH'(accept) - CNT_WIDTH'(dec);
      m_st_valid <= st_valid;
      status_error_sticky <= (st_valid & (st_error != '0)) | (status_error_sticky & !clear_sticky);
      underflow_sticky <= (st_valid & (inflight_count == '0)) | (underflow_sticky & !clear_sticky);
    end
endmodule

// File: rtl/dma_wr_desc_throttle.sv
// dma_wr_desc_throttle: per-port write-descriptor admission control with in-flight caps
module dma_wr_desc_throttle
  import dma_wr_desc_throttle_pkg::*;
#(
  parameter int PORTS = 2,
  parameter int DMA_ADDR_WIDTH = 64,
  parameter int RAM_SEL_WIDTH = 2,
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int LEN_WIDTH = 16,
  parameter int TAG_WIDTH = 8,
  parameter int OP_LIMIT = 16,
  parameter int CNT_WIDTH = cnt_width(OP_LIMIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [PORTS-1:0] enable,
  input  logic [PORTS-1:0] clear_sticky,
  dma_wr_desc_throttle_if.master bus,
  output logic [PORTS*CNT_WIDTH-1:0] inflight_count,
  output logic [PORTS-1:0] idle,
  output logic [PORTS-1:0] status_error_sticky,
  output logic [PORTS-1:0] underflow_sticky
);
  for (genvar i = 0; i < PORTS; i++) begin : g_port
    dma_wr_desc_throttle_port #(
      .DMA_ADDR_WIDTH(DMA_ADDR_WIDTH),
      .RAM_SEL_WIDTH(RAM_SEL_WIDTH),
      .RAM_ADDR_WIDTH(RAM_ADDR_WIDTH),
      .LEN_WIDTH(LEN_WIDTH),
      .TAG_WIDTH(TAG_WIDTH),
      .OP_LIMIT(OP_LIMIT),
      .CNT_WIDTH(CNT_WIDTH)
    ) u_port (
      .clk(clk),
      .rst_n(rst_n),
      .enable(enable[i]),
      .clear_sticky(clear_sticky[i]),
      .s_dma_addr(bus.s_axis_write_desc_dma_addr[i*DMA_ADDR_WIDTH +: DMA_ADDR_WIDTH]),
      .s_ram_sel(bus.s_axis_write_desc_ram_sel[i*RAM_SEL_WIDTH +: RAM_SEL_WIDTH]),
      .s_ram_addr(bus.s_axis_write_desc_ram_addr[i*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH]),
      .s_len(bus.s_axis_write_desc_len[i*LEN_WIDTH +: LEN_WIDTH]),
      .s_tag(bus.s_axis_write_desc_tag[i*TAG_WIDTH +: TAG_WIDTH]),
      .s_valid(bus.s_axis_write_desc_valid[i]),
      .s_ready(bus.s_axis_write_desc_ready[i]),
      .m_dma_addr(bus.m_axis_write_desc_dma_addr[i*DMA_ADDR_WIDTH +: DMA_ADDR_WIDTH]),
      .m_ram_sel(bus.m_axis_write_desc_ram_sel[i*RAM_SEL_WIDTH +: RAM_SEL_WIDTH]),
      .m_ram_addr(bus.m_axis_write_desc_ram_addr[i*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH]),
      .m_len(bus.m_axis_write_desc_len[i*LEN_WIDTH +: LEN_WIDTH]),
      .m_tag(bus.m_axis_write_desc_tag[i*TAG_WIDTH +: TAG_WIDTH]),
      .m_valid(bus.m_axis_write_desc_valid[i]),
      .m_ready(bus.m_axis_write_desc_ready[i]),
      .st_tag(bus.s_axis_write_desc_status_tag[i*TAG_WIDTH +: TAG_WIDTH]),
      .st_error(bus.s_axis_write_desc_status_error[i*ERR_WIDTH +: ERR_WIDTH]),
      .st_valid(bus.s_axis_write_desc_status_valid[i]),
      .m_st_tag(bus.m_axis_write_desc_status_tag[i*TAG_WIDTH +: TAG_WIDTH]),
      .m_st_error(bus.m_axis_write_desc_status_error[i*ERR_WIDTH +: ERR_WIDTH]),
      .m_st_valid(bus.m_axis_write_desc_status_valid[i]),
      .inflight_count(inflight_count[i*CNT_WIDTH +: CNT_WIDTH]),
      .idle(idle[i]),
      .status_error_sticky(status_error_sticky[i]),
      .underflow_sticky(underflow_sticky[i])
    );
  end
endmodule

// File: tb/tb_dma_wr_desc_throttle.sv
// tb_dma_wr_desc_throttle: randomized scoreboard bench against a transaction-level port model
module tb_dma_wr_desc_throttle;
  localparam int P = 2, AW = 64, SW = 2, RW = 16, LW = 16, TW = 8, LIM = 4;
  localparam int CW = $clog2(LIM + 1);
  localparam int FILL = 5, DRAIN = 6;
  typedef struct packed {
    logic [AW-1:0] a;
    logic [SW-1:0] s;
    logic [RW-1:0] r;
    logic [LW-1:0] l;
    logic [TW-1:0] t;
  } desc_t;
  typedef struct packed {
    logic [TW-1:0] t;
    logic [3:0] e;
  } st_t;
  logic clk = 0;
  logic rst_n = 0;
  logic [P-1:0] enable = '0;
  logic [P-1:0] clear_sticky = '0;
  logic [P*CW-1:0] inflight_count;
  logic [P-1:0] idle, status_error_sticky, underflow_sticky;
  dma_wr_desc_throttle_if #(.PORTS(P), .DMA_ADDR_WIDTH(AW), .RAM_SEL_WIDTH(SW), .RAM_ADDR_WIDTH(RW),
    .LEN_WIDTH(LW), .TAG_WIDTH(TW)) bus ();
  dma_wr_desc_throttle #(.PORTS(P), .DMA_ADDR_WIDTH(AW), .RAM_SEL_WIDTH(SW), .RAM_ADDR_WIDTH(RW),
    .LEN_WIDTH(LW), .TAG_WIDTH(TW), .OP_LIMIT(LIM)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .clear_sticky(clear_sticky),
    .bus(bus),
    .inflight_count(inflight_count),
    .idle(idle),
    .status_error_sticky(status_error_sticky),
    .underflow_sticky(underflow_sticky)
  );
  always #5 clk = ~clk;
  desc_t exp_d[P][$];
  st_t exp_s[P][$];
  int outstanding[P];
  int held[P];
  bit err_flag[P];
  bit und_flag[P];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, act, req, $time);
    end
  endtask
  // scoreboard monitor: pop expectations whenever the DUT hands something over
  always @(negedge clk) if (rst_n) for (int p = 0; p < P; p++) begin
    if (bus.m_axis_write_desc_valid[p] && bus.m_axis_write_desc_ready[p]) begin
      if (exp_d[p].size() == 0) chk("desc_unexpected", bus.m_axis_write_desc_valid[p], 0);
      else begin
        desc_t d;
        d = exp_d[p].pop_front();
        chk("desc_addr", bus.m_axis_write_desc_dma_addr[p*AW +: AW], d.a);
        chk("desc_fields", {bus.m_axis_write_desc_ram_sel[p*SW +: SW], bus.m_axis_write_desc_ram_addr[p*RW +: RW],
          bus.m_axis_write_desc_len[p*LW +: LW], bus.m_axis_write_desc_tag[p*TW +: TW]}, {d.s, d.r, d.l, d.t});
      end
    end
    if (bus.m_axis_write_desc_status_valid[p]) begin
      if (exp_s[p].size() == 0) chk("status_unexpected", bus.m_axis_write_desc_status_valid[p], 0);
      else begin
        st_t s;
        s = exp_s[p].pop_front();
        chk("status_tag", bus.m_axis_write_desc_status_tag[p*TW +: TW], s.t);
        chk("status_err", bus.m_axis_write_desc_status_error[p*4 +: 4], s.e);
      end
    end
  end
  function automatic bit pct(input int n);
    return $urandom_range(99) < n;
  endfunction
  task automatic model_reset();
    for (int p = 0; p < P; p++) begin
      exp_d[p].delete();
      exp_s[p].delete();
      outstanding[p] = 0;
      held[p] = 0;
      err_flag[p] = 0;
      und_flag[p] = 0;
    end
  endtask
  task automatic drive_idle();
    enable = '0;
    clear_sticky = '0;
    bus.s_axis_write_desc_valid = '0;
    bus.m_axis_write_desc_ready = '0;
    bus.s_axis_write_desc_status_valid = '0;
    bus.s_axis_write_desc_dma_addr = '0;
    bus.s_axis_write_desc_ram_sel = '0;
    bus.s_axis_write_desc_ram_addr = '0;
    bus.s_axis_write_desc_len = '0;
    bus.s_axis_write_desc_tag = '0;
    bus.s_axis_write_desc_status_tag = '0;
    bus.s_axis_write_desc_status_error = '0;
  endtask
  task automatic check_reset_state(input string n);
    for (int p = 0; p < P; p++) begin
      chk({n, "_ready"}, bus.s_axis_write_desc_ready[p], 0);
      chk({n, "_mvalid"}, bus.m_axis_write_desc_valid[p], 0);
      chk({n, "_stvalid"}, bus.m_axis_write_desc_status_valid[p], 0);
      chk({n, "_idle"}, idle[p], 1);
      chk({n, "_count"}, inflight_count[p*CW +: CW], 0);
      chk({n, "_sticky"}, {status_error_sticky[p], underflow_sticky[p]}, 0);
    end
  endtask
  // one clock of stimulus: check registered state, drive random inputs, check ready, advance model
  task automatic step(input int mode);
    bit sv[P], mr[P], stv[P], clr[P], en[P];
    desc_t d[P];
    st_t s[P];
    @(posedge clk);
    #1;
    for (int p = 0; p < P; p++) begin
      chk("count", inflight_count[p*CW +: CW], outstanding[p]);
      chk("idle", idle[p], held[p] == 0 && outstanding[p] == 0);
      chk("err_sticky", status_error_sticky[p], err_flag[p]);
      chk("und_sticky", underflow_sticky[p], und_flag[p]);
    end
    for (int p = 0; p < P; p++) begin
      en[p] = mode == 2 ? p == 0 : mode == 4 ? pct(50) : 1'b1;
      sv[p] = mode == FILL ? 1'b1 : mode == DRAIN ? 1'b0 : pct(70);
      mr[p] = (mode == FILL || mode == DRAIN) ? 1'b1 : mode == 1 ? pct(20) : pct(75);
      stv[p] = (mode == FILL || mode == DRAIN) ? 1'b0 : pct(outstanding[p] > 0 ? (mode == 3 ? 70 : 35) : 5);
      clr[p] = pct(mode == 4 ? 30 : 3);
      d[p] = {$urandom, $urandom, $urandom, $urandom};
      s[p].t = TW'($urandom);
      s[p].e = pct(25) ? 4'($urandom_range(1, 15)) : 4'h0;
      enable[p] = en[p];
      clear_sticky[p] = clr[p];
      bus.s_axis_write_desc_valid[p] = sv[p];
      bus.m_axis_write_desc_ready[p] = mr[p];
      bus.s_axis_write_desc_status_valid[p] = stv[p];
      bus.s_axis_write_desc_dma_addr[p*AW +: AW] = d[p].a;
      bus.s_axis_write_desc_ram_sel[p*SW +: SW] = d[p].s;
      bus.s_axis_write_desc_ram_addr[p*RW +: RW] = d[p].r;
      bus.s_axis_write_desc_len[p*LW +: LW] = d[p].l;
      bus.s_axis_write_desc_tag[p*TW +: TW] = d[p].t;
      bus.s_axis_write_desc_status_tag[p*TW +: TW] = s[p].t;
      bus.s_axis_write_desc_status_error[p*4 +: 4] = s[p].e;
    end
    #1;
    for (int p = 0; p < P; p++) begin
      bit rdy, acc, under;
      rdy = en[p] && outstanding[p] < LIM && (held[p] == 0 || mr[p]);
      chk("s_ready", bus.s_axis_write_desc_ready[p], rdy);
      acc = sv[p] && rdy;
      under = stv[p] && outstanding[p] == 0;
      if (mr[p]) held[p] = 0;
      if (acc) begin
        held[p] = 1;
        exp_d[p].push_back(d[p]);
        outstanding[p]++;
      end
      if (stv[p]) begin
        exp_s[p].push_back(s[p]);
        if (!under) outstanding[p]--;
      end
      if (clr[p]) begin
        err_flag[p] = 0;
        und_flag[p] = 0;
      end
      if (stv[p] && s[p].e != 0) err_flag[p] = 1;
      if (under) und_flag[p] = 1;
    end
  endtask
  initial begin
    drive_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1;
    repeat (6) step(FILL);
    repeat (200) step($urandom_range(0, 4));
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    drive_idle();
    model_reset();
    #1;
    check_reset_state("async_reset");
    @(negedge clk);
    #2;
    rst_n = 1;
    repeat (6) step(FILL);
    repeat (200) step($urandom_range(0, 4));
    repeat (8) step(DRAIN);
    @(posedge clk);
    #1;
    for (int p = 0; p < P; p++) begin
      chk("desc_left", exp_d[p].size(), 0);
      chk("status_left", exp_s[p].size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
